// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, derived totals/sync windows and the
// coordinate type used by the raster generator and its consumers.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_SYNC_DELAY = 1;

    localparam int DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Half-open window test: lo <= c < hi.
    function automatic logic in_range(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the colour generator / game logic.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic   pix_en;
    coord_t x;
    coord_t y;
    logic   bright;
    logic   hsync;
    logic   vsync;
    logic   frame_tick;

    modport master (output pix_en, x, y, bright, hsync, vsync, frame_tick);
    modport slave  (input  pix_en, x, y, bright, hsync, vsync, frame_tick);

endinterface

// File: rtl/vga_timing_gen_pix_en_div.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV system clocks.
module vga_pix_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Registered decode keeps pix_en low in reset even when CLK_DIV is 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters on the pixel enable, registered coordinates and
// blanking, sync pulses delayed to line up with the registered RGB, frame tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic         clk,
    input  logic         resetn,
    vga_timing_if.master vga
);

    localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
    localparam coord_t H_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t H_SS    = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t H_SE    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
    localparam coord_t V_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t V_SS    = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t V_SE    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic   pix_en;
    coord_t h_cnt;
    coord_t v_cnt;
    coord_t x_q;
    coord_t y_q;
    logic   bright_q;
    logic   tick_q;
    logic   bright_d;
    logic   hs_raw;
    logic   vs_raw;
    logic   tick_d;

    // Stage 0 is aligned with x/y; each further stage adds one pixel of lag.
    logic [SYNC_DELAY:0] hs_pipe;
    logic [SYNC_DELAY:0] vs_pipe;

    vga_pix_en_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk    (clk),
        .resetn (resetn),
        .pix_en (pix_en)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        bright_d = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        hs_raw   = !in_range(h_cnt, H_SS, H_SE);
        vs_raw   = !in_range(v_cnt, V_SS, V_SE);
        // Fires on the same edge that loads y = V_VISIBLE with x = 0.
        tick_d   = pix_en && (h_cnt == '0) && (v_cnt == V_VIS_C);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            bright_q <= 1'b0;
            tick_q   <= 1'b0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            tick_q <= tick_d;
            if (pix_en) begin
                x_q        <= h_cnt;
                y_q        <= v_cnt;
                bright_q   <= bright_d;
                hs_pipe[0] <= hs_raw;
                vs_pipe[0] <= vs_raw;
                for (int i = 1; i <= SYNC_DELAY; i++) begin
                    hs_pipe[i] <= hs_pipe[i-1];
                    vs_pipe[i] <= vs_pipe[i-1];
                end
            end
        end
    end

    assign vga.pix_en     = pix_en;
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.bright     = bright_q;
    assign vga.hsync      = hs_pipe[SYNC_DELAY];
    assign vga.vsync      = vs_pipe[SYNC_DELAY];
    assign vga.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line checks, a shrunken raster
// (16x12 total) for frame/wrap/tick checks, and a CLK_DIV=1 instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    vga_timing_if vf ();
    vga_timing_if vs ();
    vga_timing_if v1 ();

    vga_timing_gen u_full (
        .clk    (clk),
        .resetn (resetn),
        .vga    (vf)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(1)
    ) u_small (
        .clk    (clk),
        .resetn (resetn),
        .vga    (vs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(1)
    ) u_d1 (
        .clk    (clk),
        .resetn (resetn),
        .vga    (v1)
    );

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    bit ft_en = 1'b0;
    int ft_cnt = 0;
    int unsigned ft_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ft_en && vs.frame_tick) begin
            ft_cnt++;
            ft_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to the negedge just after the next pix_en-consuming edge.
    task automatic step_pix();
        int n = 0;
        while (!vf.pix_en && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4) chk("pe_wait", int'(vf.pix_en), 1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe_exp[6] = '{0, 1, 0, 1, 0, 1};
        int unsigned c0;
        int b_cnt, hs_cnt, hs_first;
        int sb_cnt, shs_cnt, svs_cnt, svs_first, sb_out, n_lines, line_bad, prev_y;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pix_en", vf.pix_en, 0);
        chk("rst_x", vf.x, 0);
        chk("rst_y", vf.y, 0);
        chk("rst_bright", vf.bright, 0);
        chk("rst_hsync", vf.hsync, 1);
        chk("rst_vsync", vf.vsync, 1);
        chk("rst_tick", vf.frame_tick, 0);
        chk("rst_d1_pix_en", v1.pix_en, 0);

        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pe_seq", vf.pix_en, pe_exp[i]);
            chk("pe_d1_const", v1.pix_en, 1);
            if (i == 2) begin
                chk("first_x", vf.x, 0);
                chk("first_y", vf.y, 0);
                chk("first_bright", vf.bright, 1);
                chk("first_hsync", vf.hsync, 1);
            end
        end

        // Line timing on the default raster.
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step_pix();
        chk("l0_x", vf.x, 0);
        chk("l0_y", vf.y, 0);
        c0 = cyc;
        b_cnt = 0;
        hs_cnt = 0;
        hs_first = -1;
        for (int k = 0; k < 800; k++) begin
            if (k != 0) step_pix();
            if (vf.bright) b_cnt++;
            if (!vf.hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(vf.x);
            end
        end
        chk("line_bright_cnt", b_cnt, 640);
        chk("line_hsync_low_cnt", hs_cnt, 96);
        chk("line_hsync_first_x", hs_first, 657);
        step_pix();
        chk("l1_x", vf.x, 0);
        chk("l1_y", vf.y, 1);
        chk("l1_bright", vf.bright, 1);
        chk("line_period_clk", int'(cyc - c0), 1600);

        repeat (300) step_pix();
        chk("pre_rst_x", vf.x, 300);
        chk("pre_rst_y", vf.y, 1);
        chk("pre_rst_bright", vf.bright, 1);

        // Async reset between clock edges.
        #3 resetn = 1'b0;
        #1;
        chk("arst_x", vf.x, 0);
        chk("arst_y", vf.y, 0);
        chk("arst_bright", vf.bright, 0);
        chk("arst_hsync", vf.hsync, 1);
        chk("arst_vsync", vf.vsync, 1);
        chk("arst_pix_en", vf.pix_en, 0);

        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        ft_en = 1'b1;

        // Two full frames of the 16x12 raster, then the wrap pixel.
        sb_cnt = 0; shs_cnt = 0; svs_cnt = 0; svs_first = -1; sb_out = 0;
        n_lines = 0; line_bad = 0; prev_y = 0;
        for (int k = 0; k <= 384; k++) begin
            step_pix();
            if (k == 0) begin
                chk("restart_full_x", vf.x, 0);
                chk("restart_full_y", vf.y, 0);
                chk("restart_small_bright", vs.bright, 1);
            end
            if (k > 0 && vs.x == 0) begin
                n_lines++;
                if (int'(vs.y) != (prev_y + 1) % 12) line_bad++;
                prev_y = int'(vs.y);
            end
            if (vs.frame_tick) begin
                chk("tick_x", vs.x, 0);
                chk("tick_y", vs.y, 6);
            end
            if (k < 384) begin
                if (vs.bright) sb_cnt++;
                if (vs.bright && (vs.x >= 8 || vs.y >= 6)) sb_out++;
                if (!vs.hsync) shs_cnt++;
                if (!vs.vsync) begin
                    svs_cnt++;
                    if (svs_first < 0) svs_first = int'(vs.y) * 16 + int'(vs.x);
                end
            end else begin
                chk("wrap_x", vs.x, 0);
                chk("wrap_y", vs.y, 0);
                chk("wrap_bright", vs.bright, 1);
            end
        end
        chk("frm_bright_cnt", sb_cnt, 96);
        chk("frm_bright_outside", sb_out, 0);
        chk("frm_hsync_low_cnt", shs_cnt, 72);
        chk("frm_vsync_low_cnt", svs_cnt, 64);
        chk("frm_vsync_first_pos", svs_first, 129);
        chk("frm_line_starts", n_lines, 24);
        chk("frm_line_seq_errs", line_bad, 0);
        chk("tick_count", ft_cnt, 2);
        if (ft_cyc.size() >= 2) chk("tick_period_clk", int'(ft_cyc[1] - ft_cyc[0]), 384);
        else chk("tick_period_samples", ft_cyc.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
